// File: rtl/prefetch_fetch_stage_pkg.sv
// Shared constants, pipeline handshake types and fetch-stage local types.

package constants;
  localparam logic [31:0] RESET_ADDRESS = 32'h0000_1000;
  localparam logic [31:0] MEMORY_SIZE   = 32'h0000_4000;
  localparam logic [31:0] NOP           = 32'h0000_0013;  // addi x0, x0, 0
endpackage

package pipeline_status;
  typedef enum logic {
    VALID,
    BUBBLE
  } forwards_t;

  typedef enum logic [1:0] {
    READY,
    STALL,
    JUMP
  } backwards_t;
endpackage

package prefetch_fetch_stage_pkg;
  // One prefetch buffer entry: byte PC and the instruction word fetched from it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_WIDTH = $bits(fetch_entry_t);

  // Sequential successor; wraps at the top of the 32-bit space.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Jump targets are word aligned; the low two bits are ignored.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction
endpackage

// File: rtl/wishbone_interface.sv
// Classic Wishbone bus bundle, word addressed, 32-bit data.

interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [29:0] adr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, write_data,
    input  read_data, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, write_data,
    output read_data, ack
  );
endinterface

// File: rtl/prefetch_fetch_stage_buffer.sv
// Synchronous FIFO holding prefetched {pc, instr} entries. Flush beats push and pop.

module fetch_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LEVEL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0] level_q;
  logic               do_push, do_pop;

  assign full     = (level_q == LEVEL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full & ~flush;
  assign do_pop   = pop & ~empty & ~flush;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
    end
  end

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/prefetch_fetch_stage.sv
// Instruction fetch stage that runs single-beat Wishbone reads ahead of decode into a
// small prefetch FIFO, and flushes on JUMP redirects.

module prefetch_fetch_stage
  import pipeline_status::*;
  import prefetch_fetch_stage_pkg::*;
#(
  parameter int unsigned BUFFER_DEPTH  = 4,
  parameter logic [31:0] RESET_ADDRESS = constants::RESET_ADDRESS
) (
  input  logic                                clk,
  input  logic                                rst,
  wishbone_interface.master                   wb,
  output logic [31:0]                         instruction_reg_out,
  output logic [31:0]                         program_counter_reg_out,
  output forwards_t                           status_forwards_out,
  input  backwards_t                          status_backwards_in,
  input  logic [31:0]                         jump_address_backwards_in,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]   buffer_level_out
);
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [29:0]  adr_q, adr_d;
  logic         busy_q, busy_d;
  logic         discard_q, discard_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  forwards_t    status_q, status_d;

  logic         jump, ready, push, pop, issue;
  logic         buf_full, buf_empty;
  fetch_entry_t push_entry, head;

  assign jump  = (status_backwards_in == JUMP);
  assign ready = (status_backwards_in == READY);

  // An ack is only meaningful while our own cycle is open; a redirect kills it.
  assign push  = busy_q & wb.ack & ~discard_q & ~jump;
  assign pop   = ready & ~buf_empty;
  // With no cycle open, !full is exactly level + busy < BUFFER_DEPTH.
  assign issue = ~busy_q & (jump | ~buf_full);

  assign push_entry.pc    = fetch_pc_q;
  assign push_entry.instr = wb.read_data;

  fetch_buffer #(
    .WIDTH (FETCH_ENTRY_WIDTH),
    .DEPTH (BUFFER_DEPTH)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (jump),
    .push_data (push_entry),
    .pop_data  (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .level     (buffer_level_out)
  );

  // Next-state for fetch address, bus cycle tracking and decode-facing registers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    adr_d      = adr_q;
    busy_d     = busy_q;
    discard_d  = discard_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    status_d   = status_q;

    if (jump) begin
      fetch_pc_d = align_word(jump_address_backwards_in);
    end else if (push) begin
      fetch_pc_d = next_pc(fetch_pc_q);
    end

    if (busy_q) begin
      if (wb.ack) begin
        // Close the cycle; cyc drops for one cycle after every ack.
        busy_d    = 1'b0;
        discard_d = 1'b0;
      end else if (jump) begin
        discard_d = 1'b1;
      end
    end else if (issue) begin
      // Latch the request address so adr stays stable even if a JUMP moves fetch_pc.
      busy_d = 1'b1;
      adr_d  = fetch_pc_d[31:2];
    end

    if (jump) begin
      status_d = BUBBLE;
    end else if (ready) begin
      if (!buf_empty) begin
        status_d = VALID;
        instr_d  = head.instr;
        pc_d     = head.pc;
      end else begin
        status_d = BUBBLE;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_ADDRESS;
      adr_q      <= RESET_ADDRESS[31:2];
      busy_q     <= 1'b0;
      discard_q  <= 1'b0;
      instr_q    <= constants::NOP;
      pc_q       <= RESET_ADDRESS;
      status_q   <= BUBBLE;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      adr_q      <= adr_d;
      busy_q     <= busy_d;
      discard_q  <= discard_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      status_q   <= status_d;
    end
  end

  assign wb.cyc        = busy_q;
  assign wb.stb        = busy_q;
  assign wb.we         = 1'b0;
  assign wb.sel        = 4'hF;
  assign wb.adr        = adr_q;
  assign wb.write_data = '0;

  assign instruction_reg_out     = instr_q;
  assign program_counter_reg_out = pc_q;
  assign status_forwards_out     = status_q;
endmodule
